// File: rtl/serial_tx_piso.sv
// serial_tx_piso: parallel-in/serial-out frame transmitter (start, data, optional parity, stop)
// Ports:
//   clk      - clock, all state changes on rising edge
//   rst      - synchronous active-high reset, aborts any frame in progress
//   tx_data  - word to send, sampled only when the handshake completes
//   tx_valid - tx_data holds a word to send
//   tx_ready - a word can be accepted this cycle (IDLE, or last cycle of STOP)
//   tx_out   - registered serial line, idles high
//   busy     - a frame is in progress
module serial_tx_piso #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int MSB_FIRST    = 0,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    logic [2:0]        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BW-1:0]     idx, idx_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              par, par_n, out_n, bit_end, last_bit, accept;
    assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
    assign last_bit = idx == BW'(DATA_W - 1);
    assign tx_ready = !rst && (state == IDLE || (state == STOP && bit_end));
    assign accept   = tx_valid && tx_ready;
    assign busy     = state != IDLE;
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        par_n   = accept ? ((^tx_data) ^ (PARITY_ODD != 0)) : par;
        case (state)
            IDLE: begin
                state_n = accept ? START : IDLE;
                sh_n    = accept ? tx_data : sh;
            end
            START: state_n = bit_end ? DATA : START;
            DATA: if (bit_end) begin
                // the shift register always presents the current data bit at its output end
                state_n = last_bit ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
                idx_n   = last_bit ? '0 : idx + 1'b1;
                sh_n    = last_bit ? sh : (MSB_FIRST != 0 ? sh << 1 : sh >> 1);
            end
            PARITY: state_n = bit_end ? STOP : PARITY;
            STOP: if (bit_end) begin
                state_n = accept ? START : IDLE;
                sh_n    = accept ? tx_data : sh;
            end
            default: state_n = IDLE;
        endcase
        // tx_out is registered, so the line level is derived from the next state
        out_n = state_n == START  ? 1'b0 :
                state_n == DATA   ? (MSB_FIRST != 0 ? sh_n[DATA_W-1] : sh_n[0]) :
                state_n == PARITY ? par_n : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            par    <= 1'b0;
            tx_out <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sh     <= sh_n;
            par    <= par_n;
            tx_out <= out_n;
        end
    end
endmodule
